// File: rtl/x9_run_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : x9_run_sequencer
//  Brief    : X9 run controller and program sequencer. Owns the program
//             counter, instruction-fetch handshake, lagging ALU flag
//             registers, branch decision, req/done run handshake and a
//             retired-instruction watchdog. All architectural writes in the
//             datapath are gated by the single-cycle exec_en strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module x9_run_sequencer #(
   parameter int             D         = 12,
   parameter logic [D-1:0]   HALT_ADDR = 12'hFFF,
   parameter int             W         = 16,
   parameter logic [W-1:0]   MAX_INSTR = 16'hFFFF
) (
   input  logic         clk,
   input  logic         reset,        // asynchronous, active-low
   input  logic         req,
   input  logic [D-1:0] start_addr,
   output logic         busy,
   output logic         done,
   output logic         timeout,
   output logic [D-1:0] prog_ctr,
   output logic         imem_req,
   input  logic         imem_ack,
   input  logic [8:0]   instr_in,
   output logic [8:0]   instr_q,
   output logic         exec_en,
   input  logic         branch_inst,
   input  logic         reljump_en,
   input  logic [D-1:0] target,
   input  logic         sc_o,
   input  logic         pari,
   input  logic         one,
   input  logic         sc_clr,
   input  logic         sc_en,
   output logic         sc_in,
   output logic         pari_q,
   output logic         one_q,
   output logic [W-1:0] retired
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   localparam logic [D-1:0] c_pc_one  = {{(D-1){1'b0}}, 1'b1};
   localparam logic [W:0]   c_ret_one = {{W{1'b0}}, 1'b1};

   state_t         r_state;
   state_t         w_state_nxt;
   logic [D-1:0]   r_pc;
   logic [D-1:0]   w_pc_nxt;
   logic [8:0]     r_instr;
   logic           r_sc;
   logic           r_pari;
   logic           r_one;
   logic           r_timeout;
   logic [W-1:0]   r_retired;
   logic [W:0]     w_ret_inc;
   logic           w_halt_hit;
   logic           w_wd_hit;

   // Next-PC select: absolute branch (qualified by the lagging one flag) beats relative jump
   always_comb begin
      w_pc_nxt = r_pc + c_pc_one;
      if (branch_inst && r_one) begin
         w_pc_nxt = target;
      end else if (reljump_en) begin
         w_pc_nxt = r_pc + target;
      end
   end

   // Retire count plus one, kept one bit wider so the watchdog compare cannot wrap
   assign w_ret_inc  = {1'b0, r_retired} + c_ret_one;
   assign w_halt_hit = (w_pc_nxt == HALT_ADDR);
   assign w_wd_hit   = (w_ret_inc >= {1'b0, MAX_INSTR});

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode; EXEC always lasts exactly one cycle
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:  if (req)      w_state_nxt = S_FETCH;
         S_FETCH: if (imem_ack) w_state_nxt = S_EXEC;
         S_EXEC:  w_state_nxt = (w_halt_hit || w_wd_hit) ? S_HALT : S_FETCH;
         S_HALT:  if (!req)     w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Architectural sequencer state: PC, instruction latch, flags, retire count, timeout cause
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc      <= '0;
         r_instr   <= '0;
         r_sc      <= 1'b0;
         r_pari    <= 1'b0;
         r_one     <= 1'b0;
         r_retired <= '0;
         r_timeout <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (req) begin
                  r_pc      <= start_addr;
                  r_retired <= '0;
                  r_sc      <= 1'b0;
                  r_timeout <= 1'b0;
               end
            end
            S_FETCH: begin
               if (imem_ack) begin
                  r_instr <= instr_in;
               end
            end
            S_EXEC: begin
               r_pari <= pari;
               r_one  <= one;
               if (sc_clr) begin
                  r_sc <= 1'b0;
               end else if (sc_en) begin
                  r_sc <= sc_o;
               end
               if (!w_ret_inc[W]) begin
                  r_retired <= w_ret_inc[W-1:0];
               end
               r_pc      <= w_pc_nxt;
               // Reaching HALT_ADDR is a normal end even if the watchdog also fires
               r_timeout <= w_wd_hit && !w_halt_hit;
            end
            default: begin
            end
         endcase
      end
   end

   assign busy     = (r_state == S_FETCH) || (r_state == S_EXEC);
   assign done     = (r_state == S_HALT);
   assign timeout  = r_timeout && (r_state == S_HALT);
   assign imem_req = (r_state == S_FETCH);
   assign exec_en  = (r_state == S_EXEC);
   assign prog_ctr = r_pc;
   assign instr_q  = r_instr;
   assign sc_in    = r_sc;
   assign pari_q   = r_pari;
   assign one_q    = r_one;
   assign retired  = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_x9_run_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_x9_run_sequencer
//  Brief    : Scoreboard bench for x9_run_sequencer (HALT_ADDR=4, MAX_INSTR=5).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_x9_run_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req = 1'b0;
   logic [11:0] start_addr = '0;
   logic        busy, done, timeout, imem_req, exec_en;
   logic [11:0] prog_ctr;
   logic        imem_ack = 1'b0;
   logic [8:0]  instr_in = '0;
   logic [8:0]  instr_q;
   logic        branch_inst = 1'b0, reljump_en = 1'b0;
   logic [11:0] target = '0;
   logic        sc_o = 1'b0, pari = 1'b0, one = 1'b0, sc_clr = 1'b0, sc_en = 1'b0;
   logic        sc_in, pari_q, one_q;
   logic [15:0] retired;

   x9_run_sequencer #(
      .D(12), .HALT_ADDR(12'h004), .W(16), .MAX_INSTR(16'd5)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .start_addr(start_addr),
      .busy(busy), .done(done), .timeout(timeout), .prog_ctr(prog_ctr),
      .imem_req(imem_req), .imem_ack(imem_ack), .instr_in(instr_in),
      .instr_q(instr_q), .exec_en(exec_en), .branch_inst(branch_inst),
      .reljump_en(reljump_en), .target(target), .sc_o(sc_o), .pari(pari),
      .one(one), .sc_clr(sc_clr), .sc_en(sc_en), .sc_in(sc_in),
      .pari_q(pari_q), .one_q(one_q), .retired(retired)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] pc;
      int          fc;
      logic        sc;
   } ex_rec_t;

   typedef struct {
      logic [11:0] pc;
      logic [15:0] ret;
      logic        to;
   } halt_rec_t;

   ex_rec_t   exq[$];
   halt_rec_t hq[$];
   int checks = 0;
   int errors = 0;

   // Per-address program tables consulted by the memory/control responder
   bit          t_br[4096], t_rj[4096], t_one[4096], t_sco[4096], t_sclr[4096], t_sen[4096];
   logic [11:0] t_tgt[4096];
   int          t_dly[4096];

   function automatic logic [8:0] ins_of(input logic [11:0] pc);
      return {pc[5:0], 3'b011};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 4096; i++) begin
         t_br[i] = 0; t_rj[i] = 0; t_one[i] = 0; t_sco[i] = 0;
         t_sclr[i] = 0; t_sen[i] = 0; t_tgt[i] = '0; t_dly[i] = 0;
      end
   endtask

   task automatic push_ex(input logic [11:0] pc, input int fc, input logic sc);
      ex_rec_t r;
      r.pc = pc; r.fc = fc; r.sc = sc;
      exq.push_back(r);
   endtask

   task automatic push_halt(input logic [11:0] pc, input logic [15:0] ret, input logic to);
      halt_rec_t r;
      r.pc = pc; r.ret = ret; r.to = to;
      hq.push_back(r);
   endtask

   // Run one program from sa; checks req-to-done latency, HALT hold and return to IDLE
   task automatic run_prog(input string nm, input logic [11:0] sa, input int exp_lat,
                           input int hold, input logic exp_to);
      int lat;
      start_addr = sa;
      @(negedge clk) req = 1'b1;
      @(posedge clk);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!done && lat < 400);
      if (!done) begin
         checks++; errors++;
         $display("FAIL %s_done: done never rose within %0d cycles", nm, lat);
      end else begin
         chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({nm, "_hold_done"}, 64'(done), 64'd1);
         chk({nm, "_hold_timeout"}, 64'(timeout), 64'(exp_to));
      end
      @(negedge clk) req = 1'b0;
      @(negedge clk);
      chk({nm, "_idle"}, {62'd0, done, busy}, 64'd0);
   endtask

   function automatic logic [63:0] all_outs();
      return {14'd0, busy, done, timeout, imem_req, exec_en, prog_ctr, instr_q,
              sc_in, pari_q, one_q, retired};
   endfunction

   // Memory and control responder: acks fetches after per-address wait states,
   // presents per-instruction control/flag inputs during EXEC
   initial begin
      int wcnt = 0;
      forever begin
         @(negedge clk);
         instr_in = ins_of(prog_ctr);
         if (imem_req) begin
            imem_ack = (wcnt == t_dly[prog_ctr]);
            wcnt++;
         end else begin
            imem_ack = 1'b0;
            wcnt = 0;
         end
         if (exec_en) begin
            branch_inst = t_br[prog_ctr];  reljump_en = t_rj[prog_ctr];
            target      = t_tgt[prog_ctr]; one        = t_one[prog_ctr];
            sc_o        = t_sco[prog_ctr]; sc_clr     = t_sclr[prog_ctr];
            sc_en       = t_sen[prog_ctr]; pari       = prog_ctr[0];
         end else begin
            branch_inst = 1'b0; reljump_en = 1'b0; target = '0; one = 1'b0;
            sc_o = 1'b0; sc_clr = 1'b0; sc_en = 1'b0; pari = 1'b0;
         end
      end
   end

   // Monitor: pops an expectation for every exec_en strobe and every rising done
   initial begin
      int fcnt = 0;
      logic prev_done = 1'b0;
      ex_rec_t e;
      halt_rec_t h;
      forever begin
         @(negedge clk);
         if (!reset) begin
            fcnt = 0;
         end else if (imem_req) begin
            fcnt++;
         end
         if (exec_en) begin
            if (exq.size() == 0) begin
               checks++; errors++;
               $display("FAIL sb_exec: unexpected exec_en at pc %0h", prog_ctr);
            end else begin
               e = exq.pop_front();
               chk("exec_pc", 64'(prog_ctr), 64'(e.pc));
               chk("exec_instr_q", 64'(instr_q), 64'(ins_of(e.pc)));
               chk("exec_fetch_cycles", 64'(fcnt), 64'(e.fc));
               chk("exec_sc_in", 64'(sc_in), 64'(e.sc));
            end
            fcnt = 0;
         end
         if (done && !prev_done) begin
            if (hq.size() == 0) begin
               checks++; errors++;
               $display("FAIL sb_halt: unexpected halt at pc %0h", prog_ctr);
            end else begin
               h = hq.pop_front();
               chk("halt_pc", 64'(prog_ctr), 64'(h.pc));
               chk("halt_retired", 64'(retired), 64'(h.ret));
               chk("halt_timeout", 64'(timeout), 64'(h.to));
            end
         end
         prev_done = done;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "global timeout");
   end

   initial begin
      clear_prog();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", all_outs(), 64'd0);
      @(negedge clk) reset = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", all_outs(), 64'd0);

      // Linear run 0..3 with carry set then cleared (clear beats enable)
      clear_prog();
      t_sen[0] = 1; t_sco[0] = 1;
      t_sclr[1] = 1; t_sen[1] = 1; t_sco[1] = 1;
      push_ex(12'h000, 1, 1'b0); push_ex(12'h001, 1, 1'b1);
      push_ex(12'h002, 1, 1'b0); push_ex(12'h003, 1, 1'b0);
      push_halt(12'h004, 16'd4, 1'b0);
      run_prog("linear", 12'h000, 8, 1, 1'b0);

      // Two wait states on the second fetch: imem_req held three cycles
      clear_prog();
      t_dly[1] = 2;
      push_ex(12'h000, 1, 1'b0); push_ex(12'h001, 3, 1'b0);
      push_ex(12'h002, 1, 1'b0); push_ex(12'h003, 1, 1'b0);
      push_halt(12'h004, 16'd4, 1'b0);
      run_prog("waits", 12'h000, 10, 1, 1'b0);

      // Branch priority over relative jump, and lagging one flag
      clear_prog();
      t_one[2] = 1;
      t_br[3] = 1; t_rj[3] = 1; t_tgt[3] = 12'h009;
      t_br[10] = 1; t_tgt[10] = 12'h000; t_one[10] = 1;
      push_ex(12'h001, 1, 1'b0); push_ex(12'h002, 1, 1'b0); push_ex(12'h003, 1, 1'b0);
      push_ex(12'h009, 1, 1'b0); push_ex(12'h00A, 1, 1'b0);
      push_halt(12'h00B, 16'd5, 1'b1);
      run_prog("branch", 12'h001, 10, 1, 1'b1);

      // Relative jump wraps modulo 2^12
      clear_prog();
      t_rj[12'hFFE] = 1; t_tgt[12'hFFE] = 12'h003;
      push_ex(12'hFFE, 1, 1'b0); push_ex(12'h001, 1, 1'b0);
      push_ex(12'h002, 1, 1'b0); push_ex(12'h003, 1, 1'b0);
      push_halt(12'h004, 16'd4, 1'b0);
      run_prog("wrap", 12'hFFE, 8, 1, 1'b0);

      // Halt address and watchdog reached together: not a timeout
      clear_prog();
      push_ex(12'hFFF, 1, 1'b0); push_ex(12'h000, 1, 1'b0); push_ex(12'h001, 1, 1'b0);
      push_ex(12'h002, 1, 1'b0); push_ex(12'h003, 1, 1'b0);
      push_halt(12'h004, 16'd5, 1'b0);
      run_prog("both", 12'hFFF, 10, 1, 1'b0);

      // Watchdog on a self-loop; HALT held while req stays high
      clear_prog();
      t_rj[12'h014] = 1; t_tgt[12'h014] = 12'h000;
      for (int i = 0; i < 5; i++) push_ex(12'h014, 1, 1'b0);
      push_halt(12'h014, 16'd5, 1'b1);
      run_prog("watchdog", 12'h014, 10, 3, 1'b1);

      // Async reset in the middle of a fetch
      clear_prog();
      t_dly[12'h030] = 1000;
      start_addr = 12'h030;
      @(negedge clk) req = 1'b1;
      @(negedge clk);
      chk("mid_fetch_req", 64'(imem_req), 64'd1);
      #2 reset = 1'b0; req = 1'b0;
      #1 chk("reset_mid_fetch", all_outs(), 64'd0);
      @(negedge clk) reset = 1'b1;

      // Async reset in the middle of an execute
      clear_prog();
      push_ex(12'h040, 1, 1'b0);
      start_addr = 12'h040;
      @(negedge clk) req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("mid_exec_en", 64'(exec_en), 64'd1);
      #2 reset = 1'b0; req = 1'b0;
      #1 chk("reset_mid_exec", all_outs(), 64'd0);
      @(negedge clk) reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_after_abort", all_outs(), 64'd0);

      chk("sb_empty", 64'(exq.size() + hq.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
